game_tick_sequencer: RTL and testbench

- Per-move scheduler for the two-player trail game; sits between direction control and the board RAM / renderer.
- Generates the game move tick and computes both players' next head cells from their current directions.
- Arbitrates the single-port board RAM between the two players: reads for collision checks, writes to leave trails.
- Owns game start, board clear, crash/draw detection and the game-over state.

---
 rtl/game_tick_sequencer_if.sv | 23 ++
 rtl/game_tick_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_game_tick_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_sequencer_if.sv
// Board RAM bus between the tick sequencer and the single-port board RAM.
interface game_tick_sequencer_if #(
    parameter int AW = 12
);
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_wdata;
    logic [1:0]    ram_rdata;

    modport master (
        output ram_addr,
        output ram_we,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/game_tick_sequencer.sv
// Per-move scheduler for the two-player trail game: tick, head stepping,
// board RAM arbitration, crash/draw detection and game-over state.
package game_pkg;
    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        RIGHT = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        UP    = 3'd4
    } directions;
endpackage

module game_tick_sequencer
    import game_pkg::*;
#(
    parameter int TICK_CYCLES = 32_500_000,
    parameter int GRID_W      = 64,
    parameter int GRID_H      = 48,
    parameter int P1_X0       = 16,
    parameter int P1_Y0       = 24,
    parameter int P2_X0       = 48,
    parameter int P2_Y0       = 24,
    localparam int AW = $clog2(GRID_W * GRID_H),
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  directions             direction_1,
    input  directions             direction_2,
    game_tick_sequencer_if.master ram,
    output logic [XW-1:0]         head_x1,
    output logic [YW-1:0]         head_y1,
    output logic [XW-1:0]         head_x2,
    output logic [YW-1:0]         head_y2,
    output logic                  busy,
    output logic                  game_over,
    output logic [1:0]            winner
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [AW-1:0] P1_A = AW'(P1_Y0 * GRID_W + P1_X0);
    localparam logic [AW-1:0] P2_A = AW'(P2_Y0 * GRID_W + P2_X0);
    localparam logic [AW-1:0] LAST_A = AW'(GRID_W * GRID_H - 1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, PLACE1, PLACE2, WAIT_TICK, CALC,
        RD1, RD2, CHK, WR1, WR2, OVER
    } state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  tick_cnt;
    logic [AW-1:0]  clr_addr;
    logic [XW-1:0]  hx1, hx2, nx1, nx2;
    logic [YW-1:0]  hy1, hy2, ny1, ny2;
    logic           mv1, mv2, out1, out2;
    logic [1:0]     cell1, win_q;
    logic           tick, same, crash1, crash2, go;

    // Returns {out_of_grid, next_x, next_y}; no wrap-around is ever taken.
    function automatic logic [XW+YW:0] step(
        input directions d,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        logic o;
        logic [XW-1:0] sx;
        logic [YW-1:0] sy;
        o  = 1'b0;
        sx = x;
        sy = y;
        case (d)
            RIGHT: begin o = (x == XW'(GRID_W - 1)); sx = x + XW'(1); end
            LEFT:  begin o = (x == '0);              sx = x - XW'(1); end
            DOWN:  begin o = (y == YW'(GRID_H - 1)); sy = y + YW'(1); end
            UP:    begin o = (y == '0);              sy = y - YW'(1); end
            default: ;
        endcase
        return {o, sx, sy};
    endfunction

    function automatic logic [AW-1:0] cell_addr(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        return AW'(y) * AW'(GRID_W) + AW'(x);
    endfunction

    assign tick   = (state == WAIT_TICK) && (tick_cnt == TW'(TICK_CYCLES - 1));
    assign go     = start && (state == IDLE || state == OVER);
    assign same   = (nx1 == nx2) && (ny1 == ny2);
    assign crash1 = mv1 && (out1 || cell1 != 2'b00 || (mv2 && same));
    assign crash2 = mv2 && (out2 || ram.ram_rdata != 2'b00 || (mv1 && same));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            clr_addr <= '0;
            hx1      <= XW'(P1_X0);
            hy1      <= YW'(P1_Y0);
            hx2      <= XW'(P2_X0);
            hy2      <= YW'(P2_Y0);
            nx1      <= '0;
            ny1      <= '0;
            nx2      <= '0;
            ny2      <= '0;
            mv1      <= 1'b0;
            mv2      <= 1'b0;
            out1     <= 1'b0;
            out2     <= 1'b0;
            cell1    <= 2'b00;
            win_q    <= 2'b00;
        end else begin
            state <= state_nx;

            if (state == WAIT_TICK)
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            else
                tick_cnt <= '0;

            clr_addr <= (state == CLEAR) ? clr_addr + AW'(1) : '0;

            // Heads and result are reset on entry so CLEAR already shows them.
            if (go) begin
                hx1   <= XW'(P1_X0);
                hy1   <= YW'(P1_Y0);
                hx2   <= XW'(P2_X0);
                hy2   <= YW'(P2_Y0);
                win_q <= 2'b00;
            end

            if (state == CALC) begin
                {out1, nx1, ny1} <= step(direction_1, hx1, hy1);
                {out2, nx2, ny2} <= step(direction_2, hx2, hy2);
                mv1 <= (direction_1 != WAIT);
                mv2 <= (direction_2 != WAIT);
            end

            if (state == RD2)
                cell1 <= ram.ram_rdata;

            if (state == CHK && (crash1 || crash2))
                win_q <= {crash1, crash2};

            if (state == WR1 && mv1) begin
                hx1 <= nx1;
                hy1 <= ny1;
            end

            if (state == WR2 && mv2) begin
                hx2 <= nx2;
                hy2 <= ny2;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start) state_nx = CLEAR;
            CLEAR:     if (clr_addr == LAST_A) state_nx = PLACE1;
            PLACE1:    state_nx = PLACE2;
            PLACE2:    state_nx = WAIT_TICK;
            WAIT_TICK: if (tick) state_nx = CALC;
            CALC:      state_nx = RD1;
            RD1:       state_nx = RD2;
            RD2:       state_nx = CHK;
            CHK:       state_nx = (crash1 || crash2) ? OVER : WR1;
            WR1:       state_nx = WR2;
            WR2:       state_nx = WAIT_TICK;
            OVER:      if (start) state_nx = CLEAR;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram.ram_addr  = '0;
        ram.ram_we    = 1'b0;
        ram.ram_wdata = 2'b00;
        unique case (state)
            CLEAR: begin
                ram.ram_addr = clr_addr;
                ram.ram_we   = 1'b1;
            end
            PLACE1: begin
                ram.ram_addr  = P1_A;
                ram.ram_we    = 1'b1;
                ram.ram_wdata = 2'b01;
            end
            PLACE2: begin
                ram.ram_addr  = P2_A;
                ram.ram_we    = 1'b1;
                ram.ram_wdata = 2'b10;
            end
            RD1: ram.ram_addr = cell_addr(nx1, ny1);
            RD2: ram.ram_addr = cell_addr(nx2, ny2);
            WR1: if (mv1) begin
                ram.ram_addr  = cell_addr(nx1, ny1);
                ram.ram_we    = 1'b1;
                ram.ram_wdata = 2'b01;
            end
            WR2: if (mv2) begin
                ram.ram_addr  = cell_addr(nx2, ny2);
                ram.ram_we    = 1'b1;
                ram.ram_wdata = 2'b10;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE) && (state != OVER);
    assign game_over = (state == OVER);
    assign winner    = win_q;
    assign head_x1   = hx1;
    assign head_y1   = hy1;
    assign head_x2   = hx2;
    assign head_y2   = hy2;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Directed bench for game_tick_sequencer on an 8x8 board with a 20-cycle tick;
// the bench owns the board RAM model and logs every write it receives.
module tb_game_tick_sequencer;
    import game_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      start;
    directions direction_1, direction_2;
    logic [2:0] head_x1, head_y1, head_x2, head_y2;
    logic      busy, game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    game_tick_sequencer_if #(.AW(6)) bus ();

    game_tick_sequencer #(
        .TICK_CYCLES(20), .GRID_W(8), .GRID_H(8),
        .P1_X0(2), .P1_Y0(4), .P2_X0(5), .P2_Y0(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .direction_1(direction_1), .direction_2(direction_2),
        .ram(bus),
        .head_x1(head_x1), .head_y1(head_y1),
        .head_x2(head_x2), .head_y2(head_y2),
        .busy(busy), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Board RAM model with one-cycle read latency, plus a write log.
    logic [1:0] mem [0:63];
    logic       poke_en = 1'b0;
    logic [5:0] poke_addr = '0;
    logic [1:0] poke_data = '0;
    logic [5:0] wr_a [0:1023];
    logic [1:0] wr_d [0:1023];
    int         wr_n = 0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we && wr_n < 1024) begin
            wr_a[wr_n] <= bus.ram_addr;
            wr_d[wr_n] <= bus.ram_wdata;
            wr_n <= wr_n + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full move period: 20 WAIT_TICK cycles plus CALC..WR2.
    task automatic tick();
        cyc(26);
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(66);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        direction_1 = WAIT;
        direction_2 = WAIT;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || game_over !== 1'b0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL reset_status busy=%b over=%b win=%b want 0/0/00",
                     busy, game_over, winner);
        end
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 6'd0 || bus.ram_wdata !== 2'b00) begin
            errors++;
            $display("FAIL reset_bus we=%b addr=%0d wd=%b want 0/0/00",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        checks++;
        if (head_x1 !== 3'd2 || head_y1 !== 3'd4 || head_x2 !== 3'd5 || head_y2 !== 3'd4) begin
            errors++;
            $display("FAIL reset_heads got (%0d,%0d)/(%0d,%0d) want (2,4)/(5,4)",
                     head_x1, head_y1, head_x2, head_y2);
        end
    endtask

    task automatic test_clear();
        int base;
        int busy_lo;
        int bad;
        base = wr_n;
        busy_lo = 0;
        bad = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 66; i++) begin
            if (busy !== 1'b1) busy_lo++;
            @(negedge clk);
        end
        checks++;
        if (wr_n - base != 66) begin
            errors++;
            $display("FAIL clear_count got %0d want 66", wr_n - base);
        end
        for (int k = 0; k < 64; k++)
            if (wr_a[base+k] !== 6'(k) || wr_d[base+k] !== 2'b00) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_seq bad_entries got %0d want 0", bad);
        end
        checks++;
        if (wr_a[base+64] !== 6'd34 || wr_d[base+64] !== 2'b01 ||
            wr_a[base+65] !== 6'd37 || wr_d[base+65] !== 2'b10) begin
            errors++;
            $display("FAIL place got %0d:%b %0d:%b want 34:01 37:10",
                     wr_a[base+64], wr_d[base+64], wr_a[base+65], wr_d[base+65]);
        end
        checks++;
        if (busy_lo != 0 || busy !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy low_cycles=%0d busy=%b we=%b want 0/1/0",
                     busy_lo, busy, bus.ram_we);
        end
    endtask

    task automatic test_collide();
        int base;
        direction_1 = RIGHT;
        direction_2 = LEFT;
        base = wr_n;
        tick();
        checks++;
        if (head_x1 !== 3'd3 || head_y1 !== 3'd4 || head_x2 !== 3'd4 || head_y2 !== 3'd4) begin
            errors++;
            $display("FAIL move1_heads got (%0d,%0d)/(%0d,%0d) want (3,4)/(4,4)",
                     head_x1, head_y1, head_x2, head_y2);
        end
        checks++;
        if (wr_n - base != 2 || wr_a[base] !== 6'd35 || wr_d[base] !== 2'b01 ||
            wr_a[base+1] !== 6'd36 || wr_d[base+1] !== 2'b10) begin
            errors++;
            $display("FAIL move1_writes n=%0d %0d:%b %0d:%b want 2 35:01 36:10",
                     wr_n - base, wr_a[base], wr_d[base], wr_a[base+1], wr_d[base+1]);
        end
        base = wr_n;
        tick();
        checks++;
        if (winner !== 2'b11 || game_over !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL draw win=%b over=%b busy=%b want 11/1/0",
                     winner, game_over, busy);
        end
        checks++;
        if (wr_n != base || head_x1 !== 3'd3 || head_x2 !== 3'd4) begin
            errors++;
            $display("FAIL draw_nowrite writes=%0d x1=%0d x2=%0d want 0/3/4",
                     wr_n - base, head_x1, head_x2);
        end
    endtask

    task automatic test_restart();
        int base;
        direction_1 = WAIT;
        direction_2 = WAIT;
        base = wr_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (winner !== 2'b00 || game_over !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart win=%b over=%b busy=%b want 00/0/1",
                     winner, game_over, busy);
        end
        checks++;
        if (head_x1 !== 3'd2 || head_y1 !== 3'd4 || head_x2 !== 3'd5 || head_y2 !== 3'd4) begin
            errors++;
            $display("FAIL restart_heads got (%0d,%0d)/(%0d,%0d) want (2,4)/(5,4)",
                     head_x1, head_y1, head_x2, head_y2);
        end
        cyc(66);
        checks++;
        if (wr_n - base != 66 || wr_a[base] !== 6'd0 || wr_a[base+63] !== 6'd63) begin
            errors++;
            $display("FAIL restart_clear n=%0d first=%0d last=%0d want 66/0/63",
                     wr_n - base, wr_a[base], wr_a[base+63]);
        end
    endtask

    task automatic test_out_of_grid();
        int base;
        direction_1 = UP;
        direction_2 = WAIT;
        repeat (4) tick();
        checks++;
        if (head_x1 !== 3'd2 || head_y1 !== 3'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL up_walk got (%0d,%0d) over=%b want (2,0) 0",
                     head_x1, head_y1, game_over);
        end
        base = wr_n;
        tick();
        checks++;
        if (winner !== 2'b10 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL out_grid win=%b over=%b want 10/1", winner, game_over);
        end
        checks++;
        if (wr_n != base || head_y1 !== 3'd0 || head_x2 !== 3'd5 || head_y2 !== 3'd4) begin
            errors++;
            $display("FAIL out_grid_hold writes=%0d y1=%0d p2=(%0d,%0d) want 0/0/(5,4)",
                     wr_n - base, head_y1, head_x2, head_y2);
        end
    endtask

    task automatic test_p2_crash();
        int base;
        direction_1 = WAIT;
        direction_2 = WAIT;
        start_game();
        poke_addr = 6'd38;
        poke_data = 2'b01;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
        direction_1 = DOWN;
        direction_2 = RIGHT;
        base = wr_n;
        tick();
        checks++;
        if (winner !== 2'b01 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL p2_crash win=%b over=%b want 01/1", winner, game_over);
        end
        checks++;
        if (wr_n != base || mem[42] !== 2'b00 || head_y1 !== 3'd4 || head_x2 !== 3'd5) begin
            errors++;
            $display("FAIL p2_crash_hold writes=%0d m42=%b y1=%0d x2=%0d want 0/00/4/5",
                     wr_n - base, mem[42], head_y1, head_x2);
        end
    endtask

    task automatic test_wait_hold();
        int base;
        direction_1 = WAIT;
        direction_2 = WAIT;
        start_game();
        base = wr_n;
        cyc(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(72);
        checks++;
        if (wr_n != base || game_over !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_hold writes=%0d over=%b busy=%b want 0/0/1",
                     wr_n - base, game_over, busy);
        end
        checks++;
        if (head_x1 !== 3'd2 || head_y1 !== 3'd4 || head_x2 !== 3'd5 || head_y2 !== 3'd4) begin
            errors++;
            $display("FAIL wait_heads got (%0d,%0d)/(%0d,%0d) want (2,4)/(5,4)",
                     head_x1, head_y1, head_x2, head_y2);
        end
    endtask

    task automatic test_reset_mid_clear();
        int base;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = wr_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(30);
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 6'd30) begin
            errors++;
            $display("FAIL mid_clear_pos we=%b addr=%0d want 1/30", bus.ram_we, bus.ram_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 6'd0 || busy !== 1'b0 ||
            game_over !== 1'b0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL mid_clear_rst we=%b addr=%0d busy=%b over=%b win=%b want 0/0/0/0/00",
                     bus.ram_we, bus.ram_addr, busy, game_over, winner);
        end
        rst = 1'b0;
        cyc(5);
        checks++;
        if (wr_n - base != 31 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_abort writes=%0d busy=%b want 31/0", wr_n - base, busy);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_collide();
        test_restart();
        test_out_of_grid();
        test_p2_crash();
        test_wait_hold();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
